// File: rtl/fm_capture_ctrl_if.sv
// Write-side bus between the pixel pipeline / readout controller and fm_capture_ctrl.
// drop_count exists only when FM_DROP_CNT_EN is defined.
interface fm_capture_ctrl_if #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 6
);
  logic               data_rdy;
  logic [COORD_W-1:0] x_coord;
  logic [COORD_W-1:0] y_coord;
  logic               read_done;
  logic               wren;
  logic [ADDR_W-1:0]  wr_addr;
  logic               buffer_full;
`ifdef FM_DROP_CNT_EN
  logic [15:0]        drop_count;

  modport master (
    output data_rdy, x_coord, y_coord, read_done,
    input  wren, wr_addr, buffer_full, drop_count
  );
  modport slave (
    input  data_rdy, x_coord, y_coord, read_done,
    output wren, wr_addr, buffer_full, drop_count
  );
`else
  modport master (
    output data_rdy, x_coord, y_coord, read_done,
    input  wren, wr_addr, buffer_full
  );
  modport slave (
    input  data_rdy, x_coord, y_coord, read_done,
    output wren, wr_addr, buffer_full
  );
`endif
endinterface

// File: rtl/fm_capture_ctrl.sv
// Feature-map write controller: maps bottom-right kernel coords to fm_buffer write addresses.
// wren/wr_addr lag data_rdy by one clock, so rectified_vector must be delayed one register
// by the integrator. FM_DROP_CNT_EN adds a saturating count of pixels dropped while full.
//
// state | meaning
// FILL  | capturing pixels; the write to the last address moves to FULL
// FULL  | map complete, buffer_full held, pixels dropped until read_done
module fm_capture_ctrl #(
  parameter int FM_WIDTH    = 8,
  parameter int FM_HEIGHT   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int COORD_W     = 10,
  parameter int ADDR_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  fm_capture_ctrl_if.slave fm
);

  localparam logic [COORD_W-1:0] OFFSET    = COORD_W'(KERNEL_SIZE - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(FM_WIDTH * FM_HEIGHT - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t              state;
  logic                wren_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                full_q;
  logic [COORD_W-1:0]  fx;
  logic [COORD_W-1:0]  fy;
  logic                in_range;
  logic [ADDR_W-1:0]   addr;

  // Underflow is rejected explicitly, so the wrapped fx/fy values are never used.
  always_comb begin
    fx       = fm.x_coord - OFFSET;
    fy       = fm.y_coord - OFFSET;
    in_range = (fm.x_coord >= OFFSET) && (fm.y_coord >= OFFSET) &&
               (fx < COORD_W'(FM_WIDTH)) && (fy < COORD_W'(FM_HEIGHT));
    addr     = ADDR_W'(fy) * ADDR_W'(FM_WIDTH) + ADDR_W'(fx);
  end

`ifdef FM_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FILL;
      wren_q    <= 1'b0;
      wr_addr_q <= '0;
      full_q    <= 1'b0;
`ifdef FM_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      case (state)
        FILL: begin
          wren_q <= fm.data_rdy && in_range;
          if (fm.data_rdy && in_range) begin
            wr_addr_q <= addr;
            if (addr == LAST_ADDR) begin
              state  <= FULL;
              full_q <= 1'b1;
            end
          end
        end
        FULL: begin
          wren_q <= 1'b0;
          if (fm.read_done) begin
            state  <= FILL;
            full_q <= 1'b0;
          end
`ifdef FM_DROP_CNT_EN
          if (fm.data_rdy && (drop_cnt_q != 16'hFFFF))
            drop_cnt_q <= drop_cnt_q + 16'd1;
`endif
        end
        default: begin
          state  <= FILL;
          wren_q <= 1'b0;
          full_q <= 1'b0;
        end
      endcase
    end
  end

  assign fm.wren        = wren_q;
  assign fm.wr_addr     = wr_addr_q;
  assign fm.buffer_full = full_q;
`ifdef FM_DROP_CNT_EN
  assign fm.drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fm_capture_ctrl.sv
// Scoreboard bench for fm_capture_ctrl: stimulus queues expected writes, a monitor pops them.
module tb_fm_capture_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fm_capture_ctrl_if #(.COORD_W(10), .ADDR_W(6)) bus ();

  fm_capture_ctrl #(
    .FM_WIDTH(8), .FM_HEIGHT(8), .KERNEL_SIZE(3), .COORD_W(10), .ADDR_W(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fm(bus)
  );

  typedef struct {
    logic [5:0] addr;
    logic       full;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (bus.wren) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0d expected no write (cycle %0d)",
                   bus.wr_addr, cyc);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", int'(bus.wr_addr), int'(e.addr));
          chk("full_with_write", int'(bus.buffer_full), int'(e.full));
          chk("write_cycle", cyc, e.cyc);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL missing_write: got no write expected addr=%0d (cycle %0d)", e.addr, cyc);
      end
    end
  end

  task automatic step(input logic dr, input int x, input int y, input logic rd,
                      input logic wr_e, input int addr_e, input logic full_e);
    exp_t e;
    @(negedge clock);
    bus.data_rdy  = dr;
    bus.x_coord   = 10'(x);
    bus.y_coord   = 10'(y);
    bus.read_done = rd;
    if (wr_e) begin
      e.addr = 6'(addr_e);
      e.full = full_e;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic sweep();
    for (int y = 2; y <= 9; y++)
      for (int x = 2; x <= 9; x++)
        step(1'b1, x, y, 1'b0, 1'b1, (y - 2) * 8 + (x - 2), ((y - 2) * 8 + (x - 2)) == 63);
  endtask

  initial begin : watchdog
    #50000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stim
    bus.data_rdy  = 1'b0;
    bus.x_coord   = '0;
    bus.y_coord   = '0;
    bus.read_done = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_wren", int'(bus.wren), 0);
    chk("reset_wr_addr", int'(bus.wr_addr), 0);
    chk("reset_full", int'(bus.buffer_full), 0);
`ifdef FM_DROP_CNT_EN
    chk("reset_drop", int'(bus.drop_count), 0);
`endif
    reset  = 1'b0;
    mon_en = 1'b1;

    // First in-range pixel lands at address 0.
    step(1'b1, 2, 2, 1'b0, 1'b1, 0, 1'b0);
    idle();
    chk("first_full", int'(bus.buffer_full), 0);

    // Underflow and overrange pixels are rejected; address holds.
    step(1'b1, 1, 5, 1'b0, 1'b0, 0, 1'b0);
    idle();
    chk("underflow_wren", int'(bus.wren), 0);
    step(1'b1, 10, 4, 1'b0, 1'b0, 0, 1'b0);
    idle();
    chk("overrange_wren", int'(bus.wren), 0);
    chk("hold_wr_addr", int'(bus.wr_addr), 0);

    sweep();
    idle();
    chk("sweep_full", int'(bus.buffer_full), 1);
    idle();
    chk("full_idle_wren", int'(bus.wren), 0);
    chk("full_held", int'(bus.buffer_full), 1);

    // Pixels while FULL are dropped.
    repeat (5) step(1'b1, 5, 5, 1'b0, 1'b0, 0, 1'b0);
    idle();
    chk("drop_wren", int'(bus.wren), 0);
    chk("drop_full", int'(bus.buffer_full), 1);
`ifdef FM_DROP_CNT_EN
    chk("drop_count5", int'(bus.drop_count), 5);
`endif

    step(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
    idle();
    chk("read_done_clear", int'(bus.buffer_full), 0);
    step(1'b1, 3, 2, 1'b0, 1'b1, 1, 1'b0);
    idle();
    chk("resume_wren", int'(bus.wren), 1);
    chk("resume_addr", int'(bus.wr_addr), 1);

    // Reset in the middle of a fill.
    for (int i = 0; i < 20; i++)
      step(1'b1, 2 + i % 8, 2 + i / 8, 1'b0, 1'b1, i, 1'b0);
    @(negedge clock);
    bus.data_rdy = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_wren", int'(bus.wren), 0);
    chk("midreset_addr", int'(bus.wr_addr), 0);
    chk("midreset_full", int'(bus.buffer_full), 0);
`ifdef FM_DROP_CNT_EN
    chk("midreset_drop", int'(bus.drop_count), 0);
`endif
    reset = 1'b0;

    sweep();
    idle();
    chk("resweep_full", int'(bus.buffer_full), 1);

    // Pixel coincident with read_done is dropped (and counted).
    step(1'b1, 2, 2, 1'b1, 1'b0, 0, 1'b0);
    idle();
    chk("rd_same_cycle_wren", int'(bus.wren), 0);
    chk("rd_same_cycle_full", int'(bus.buffer_full), 0);
`ifdef FM_DROP_CNT_EN
    chk("drop_count_rd_cycle", int'(bus.drop_count), 1);
`endif

    // read_done during FILL is ignored.
    step(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 9, 2, 1'b1, 1'b1, 7, 1'b0);
    step(1'b1, 2, 3, 1'b0, 1'b1, 8, 1'b0);
    idle();
    chk("fill_rd_full", int'(bus.buffer_full), 0);
    chk("fill_rd_addr", int'(bus.wr_addr), 8);

    repeat (3) idle();
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
